// File: rtl/tx_sym_pkg.sv
// Symbol constants and FSM state encoding shared by the transmit symbol sequencer.
package tx_sym_pkg;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] SKP    = 8'h1C;
    localparam logic [7:0] D10_2  = 8'h4A;
    localparam logic [7:0] D21_5  = 8'hB5;
    localparam logic [7:0] IDLE_D = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_NORMAL,
        ST_SKP,
        ST_COMPLIANCE
    } state_t;

endpackage

// File: rtl/skp_timer.sv
// Counts NORMAL cycles and raises a saturating pending flag once the SKP interval has elapsed.
module skp_timer #(
    parameter int INTERVAL = 1180
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic clr,
    input  logic inc,
    output logic pending
);

    localparam int TW = $clog2(INTERVAL);
    localparam logic [TW-1:0] TERM = TW'(INTERVAL - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (!rst_b || clr) begin
            cnt <= '0;
        end else if (inc && cnt != TERM) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign pending = (cnt == TERM);

endmodule

// File: rtl/tx_symbol_sequencer.sv
// Transmit-side symbol sequencer feeding the 8b/10b encoder: alignment, packet pass-through,
// SKP ordered-set insertion between packets and the compliance pattern.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | link disabled, emits D0.0; picks ALIGN or COMPLIANCE on enable
// ST_ALIGN      | ALIGN_LEN symbols alternating K28.5 / D10.2
// ST_NORMAL     | packet bytes via valid/ready, D0.0 when nothing offered
// ST_SKP        | K28.5 then SKP_LEN x K28.0
// ST_COMPLIANCE | repeating K28.5, D21.5, K28.5, D10.2 with TXCOMP on the first
module tx_symbol_sequencer
    import tx_sym_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_LEN      = 3,
    parameter int ALIGN_LEN    = 16
) (
    input  logic       INTERCLK,
    input  logic       Reset,
    input  logic       iEnable,
    input  logic       iCompliance,
    input  logic       iValid,
    output logic       oReady,
    input  logic [7:0] iData,
    input  logic       iDataK,
    input  logic       iLast,
    output logic [7:0] oData,
    output logic       oTXDATAK,
    output logic       oTXCOMP,
    output logic       oAligned
);

    localparam int CMAX = (ALIGN_LEN > 8) ? ALIGN_LEN : 8;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] ALIGN_LAST = CW'(ALIGN_LEN - 1);
    localparam logic [CW-1:0] SKP_LAST   = CW'(SKP_LEN);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] sym_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          in_pkt;
    logic          in_pkt_nxt;
    logic          skp_pending;
    logic          skp_clr;
    logic          xfer;
    logic [7:0]    sym_d;
    logic          symk_d;
    logic          comp_d;
    logic          aligned_d;

    // A pending SKP only blocks new bytes between packets, so packets are never split.
    assign oReady    = (state == ST_NORMAL) && !(skp_pending && !in_pkt) && iEnable;
    assign xfer      = iValid && oReady;
    assign aligned_d = iEnable && ((state == ST_NORMAL) || (state == ST_SKP));
    assign skp_clr   = !((state == ST_NORMAL) && (state_nxt == ST_NORMAL));

    skp_timer #(
        .INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk_sys (INTERCLK),
        .rst_b   (Reset),
        .clr     (skp_clr),
        .inc     (!skp_clr),
        .pending (skp_pending)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = '0;
        in_pkt_nxt = in_pkt;
        sym_d      = IDLE_D;
        symk_d     = 1'b0;
        comp_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = iCompliance ? ST_COMPLIANCE : ST_ALIGN;
            end
            ST_ALIGN: begin
                sym_d  = sym_cnt[0] ? D10_2 : COM;
                symk_d = ~sym_cnt[0];
                if (sym_cnt == ALIGN_LAST) begin
                    state_nxt = ST_NORMAL;
                end else begin
                    cnt_nxt = sym_cnt + 1'b1;
                end
            end
            ST_NORMAL: begin
                if (xfer) begin
                    sym_d      = iData;
                    symk_d     = iDataK;
                    in_pkt_nxt = ~iLast;
                end
                // Entering straight off the iLast transfer keeps SKP glued to the packet end.
                if (skp_pending && !in_pkt_nxt) begin
                    state_nxt = ST_SKP;
                end
            end
            ST_SKP: begin
                sym_d  = (sym_cnt == '0) ? COM : SKP;
                symk_d = 1'b1;
                if (sym_cnt == SKP_LAST) begin
                    state_nxt = ST_NORMAL;
                end else begin
                    cnt_nxt = sym_cnt + 1'b1;
                end
            end
            ST_COMPLIANCE: begin
                case (sym_cnt[1:0])
                    2'd0: begin
                        sym_d  = COM;
                        symk_d = 1'b1;
                        comp_d = 1'b1;
                    end
                    2'd1: sym_d = D21_5;
                    2'd2: begin
                        sym_d  = COM;
                        symk_d = 1'b1;
                    end
                    default: sym_d = D10_2;
                endcase
                cnt_nxt = {{(CW-2){1'b0}}, sym_cnt[1:0] + 2'd1};
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (!iEnable) begin
            state_nxt  = ST_IDLE;
            cnt_nxt    = '0;
            in_pkt_nxt = 1'b0;
            sym_d      = IDLE_D;
            symk_d     = 1'b0;
            comp_d     = 1'b0;
        end
    end

    always_ff @(posedge INTERCLK) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            sym_cnt  <= '0;
            in_pkt   <= 1'b0;
            oData    <= IDLE_D;
            oTXDATAK <= 1'b0;
            oTXCOMP  <= 1'b0;
            oAligned <= 1'b0;
        end else begin
            state    <= state_nxt;
            sym_cnt  <= cnt_nxt;
            in_pkt   <= in_pkt_nxt;
            oData    <= sym_d;
            oTXDATAK <= symk_d;
            oTXCOMP  <= comp_d;
            oAligned <= aligned_d;
        end
    end

endmodule

// File: tb/tb_tx_symbol_sequencer.sv
// Self-checking bench for tx_symbol_sequencer: vector table, hand-written corner sequences and
// randomized traffic, all compared against a stream-level reference model.
module tb_tx_symbol_sequencer;

    localparam int I  = 20;
    localparam int SL = 3;
    localparam int AL = 16;

    localparam int P_IDLE  = 0;
    localparam int P_ALIGN = 1;
    localparam int P_NORM  = 2;
    localparam int P_SKP   = 3;
    localparam int P_COMP  = 4;

    logic       INTERCLK    = 1'b0;
    logic       Reset       = 1'b0;
    logic       iEnable     = 1'b0;
    logic       iCompliance = 1'b0;
    logic       iValid      = 1'b0;
    logic [7:0] iData       = 8'h00;
    logic       iDataK      = 1'b0;
    logic       iLast       = 1'b0;
    logic       oReady;
    logic [7:0] oData;
    logic       oTXDATAK;
    logic       oTXCOMP;
    logic       oAligned;

    tx_symbol_sequencer #(
        .SKP_INTERVAL(I),
        .SKP_LEN     (SL),
        .ALIGN_LEN   (AL)
    ) dut (
        .INTERCLK    (INTERCLK),
        .Reset       (Reset),
        .iEnable     (iEnable),
        .iCompliance (iCompliance),
        .iValid      (iValid),
        .oReady      (oReady),
        .iData       (iData),
        .iDataK      (iDataK),
        .iLast       (iLast),
        .oData       (oData),
        .oTXDATAK    (oTXDATAK),
        .oTXCOMP     (oTXCOMP),
        .oAligned    (oAligned)
    );

    always #5 INTERCLK = ~INTERCLK;

    typedef struct {
        bit         en;
        bit         valid;
        logic [7:0] d;
        bit         last;
        bit         rdy;
        logic [7:0] od;
        bit         ok;
        bit         oa;
    } vec_t;

    vec_t       tbl [22];
    logic [9:0] comp_pat [4];   // {data, K, TXCOMP}

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase, position inside the current fixed pattern, NORMAL symbols since
    // the last SKP (or NORMAL entry), and whether a packet is open.
    int m_phase = P_IDLE;
    int m_pos   = 0;
    int m_norm  = 0;
    bit m_inpkt = 1'b0;
    bit rdy_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit rst, input bit en, input bit comp, input bit valid,
                         input logic [7:0] d, input bit k, input bit last);
        bit         m_rdy;
        bit         xfer;
        logic [7:0] ed;
        bit         ek;
        bit         ec;
        bit         ea;
        Reset       = rst;
        iEnable     = en;
        iCompliance = comp;
        iValid      = valid;
        iData       = d;
        iDataK      = k;
        iLast       = last;
        #1;
        rdy_seen = oReady;
        m_rdy    = rst && en && (m_phase == P_NORM) && !((m_norm >= I - 1) && !m_inpkt);
        if (rst) check("ready", oReady, m_rdy);
        xfer = valid && m_rdy;
        ed = 8'h00; ek = 1'b0; ec = 1'b0; ea = 1'b0;
        if (!rst || !en) begin
            m_phase = P_IDLE; m_pos = 0; m_norm = 0; m_inpkt = 1'b0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    m_phase = comp ? P_COMP : P_ALIGN;
                    m_pos   = 0;
                end
                P_ALIGN: begin
                    if (m_pos % 2 == 0) begin ed = 8'hBC; ek = 1'b1; end
                    else ed = 8'h4A;
                    m_pos++;
                    if (m_pos == AL) begin m_phase = P_NORM; m_norm = 0; end
                end
                P_NORM: begin
                    ea = 1'b1;
                    if (xfer) begin
                        ed = d; ek = k; m_inpkt = !last;
                    end
                    if ((m_norm >= I - 1) && !m_inpkt) begin
                        m_phase = P_SKP; m_pos = 0; m_norm = 0;
                    end else begin
                        m_norm++;
                    end
                end
                P_SKP: begin
                    ea = 1'b1; ek = 1'b1;
                    ed = (m_pos == 0) ? 8'hBC : 8'h1C;
                    m_pos++;
                    if (m_pos == SL + 1) begin m_phase = P_NORM; m_norm = 0; end
                end
                default: begin
                    {ed, ek, ec} = comp_pat[m_pos % 4];
                    m_pos++;
                end
            endcase
        end
        @(posedge INTERCLK);
        #1;
        check("symbol", {oData, oTXDATAK, oTXCOMP, oAligned}, {ed, ek, ec, ea});
    endtask

    initial begin
        int low_cnt;
        comp_pat[0] = {8'hBC, 1'b1, 1'b1};
        comp_pat[1] = {8'hB5, 1'b0, 1'b0};
        comp_pat[2] = {8'hBC, 1'b1, 1'b0};
        comp_pat[3] = {8'h4A, 1'b0, 1'b0};

        tbl[0] = '{1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
        for (int i = 1; i <= AL; i++)
            tbl[i] = '{1, 0, 8'h00, 0, 0, (i % 2 == 1) ? 8'hBC : 8'h4A, (i % 2 == 1), 0};
        tbl[17] = '{1, 0, 8'h00, 0, 1, 8'h00, 0, 1};
        tbl[18] = '{1, 1, 8'h11, 0, 1, 8'h11, 0, 1};
        tbl[19] = '{1, 1, 8'h22, 0, 1, 8'h22, 0, 1};
        tbl[20] = '{1, 1, 8'h33, 1, 1, 8'h33, 0, 1};
        tbl[21] = '{1, 0, 8'h00, 0, 1, 8'h00, 0, 1};

        // Reset held two cycles with enable already requested.
        repeat (2) begin
            cycle(0, 1, 0, 0, 8'h00, 0, 0);
            check("reset_out", {oData, oTXDATAK, oTXCOMP, oAligned}, 0);
        end

        // Alignment burst and packet pass-through.
        for (int i = 0; i < 22; i++) begin
            cycle(1, tbl[i].en, 0, tbl[i].valid, tbl[i].d, 0, tbl[i].last);
            check($sformatf("tbl%0d_ready", i), rdy_seen, tbl[i].rdy);
            check($sformatf("tbl%0d_out", i), {oData, oTXDATAK, oAligned},
                  {tbl[i].od, tbl[i].ok, tbl[i].oa});
        end

        // 10-byte packet straddling the SKP interval: SKP deferred until right after iLast.
        repeat (9) cycle(1, 1, 0, 0, 8'h00, 0, 0);
        for (int b = 0; b < 10; b++) begin
            cycle(1, 1, 0, 1, 8'h40 + b[7:0], 0, (b == 9));
            check("defer_ready", rdy_seen, 1);
            check("defer_byte", oData, 8'h40 + b);
        end
        for (int s = 0; s < 4; s++) begin
            cycle(1, 1, 0, 1, 8'hEE, 0, 0);
            check("skp_ready", rdy_seen, 0);
            check("skp_sym", {oData, oTXDATAK}, {(s == 0) ? 8'hBC : 8'h1C, 1'b1});
        end
        cycle(1, 1, 0, 0, 8'h00, 0, 0);
        check("skp_ready_back", rdy_seen, 1);

        // Randomized traffic with occasional enable drops and compliance requests.
        for (int n = 0; n < 600; n++) begin
            cycle(1, ($urandom_range(99) != 0), $urandom_range(1), ($urandom_range(9) < 7),
                  8'($urandom_range(255)), ($urandom_range(9) == 0), ($urandom_range(3) == 0));
        end

        // Disable mid-packet, then realign and check the stale packet does not linger.
        cycle(1, 0, 0, 0, 8'h00, 0, 0);
        cycle(1, 1, 0, 0, 8'h00, 0, 0);
        repeat (AL) cycle(1, 1, 0, 0, 8'h00, 0, 0);
        cycle(1, 1, 0, 1, 8'h5A, 0, 0);
        check("pkt_a_ready", rdy_seen, 1);
        cycle(1, 1, 0, 1, 8'h5B, 0, 0);
        cycle(1, 0, 0, 1, 8'h5C, 0, 0);
        check("dis_ready", rdy_seen, 0);
        check("dis_out", {oData, oTXDATAK, oTXCOMP, oAligned}, 0);
        cycle(1, 1, 0, 0, 8'h00, 0, 0);
        check("realign_idle", {oData, oAligned}, 0);
        for (int a = 0; a < AL; a++) begin
            cycle(1, 1, 0, 0, 8'h00, 0, 0);
            check("realign_sym", {oData, oTXDATAK},
                  (a % 2 == 0) ? {8'hBC, 1'b1} : {8'h4A, 1'b0});
        end
        low_cnt = 0;
        for (int c = 0; c < 26; c++) begin
            cycle(1, 1, 0, 0, 8'h00, 0, 0);
            if (!rdy_seen) low_cnt++;
        end
        check("idle_skp_ready_low", low_cnt, 5);
        cycle(1, 1, 0, 1, 8'hC1, 0, 0);
        check("pkt_b_ready", rdy_seen, 1);
        check("pkt_b_byte", {oData, oAligned}, {8'hC1, 1'b1});
        cycle(1, 1, 0, 1, 8'hC2, 0, 1);
        check("pkt_b_last", oData, 8'hC2);

        // Compliance pattern; iCompliance dropped mid-run must be ignored.
        cycle(1, 0, 1, 0, 8'h00, 0, 0);
        cycle(1, 1, 1, 0, 8'h00, 0, 0);
        check("comp_entry", {oData, oTXCOMP}, 0);
        for (int c = 0; c < 12; c++) begin
            cycle(1, 1, (c < 6), 0, 8'h00, 0, 0);
            check("comp_ready", rdy_seen, 0);
            check("comp_sym", {oData, oTXDATAK, oTXCOMP}, comp_pat[c % 4]);
        end
        cycle(1, 0, 0, 0, 8'h00, 0, 0);
        check("comp_exit", {oData, oTXDATAK, oTXCOMP, oAligned}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
